fixed_div_seq: RTL and testbench

//  Parametrised sequential signed-magnitude fixed-point divider. Produces one quotient bit per cycle.

---
 rtl/fixed_div_seq.sv | 140 ++++++++++++++
 tb/tb_fixed_div_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/fixed_div_seq.sv
// Sequential signed-magnitude Q-format divider, one quotient bit per cycle.
// Valid/ready on both sides, divide-by-zero flag, optional rounding and saturation.
module fixed_div_seq #(
  parameter int N        = 32,
  parameter int Q        = 15,
  parameter int ROUND    = 0,
  parameter int SATURATE = 1
) (
  input  logic         i_clk,
  input  logic         rst,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [N-1:0] o_quotient,
  output logic         o_overflow,
  output logic         o_dbz,
  output logic         o_valid,
  input  logic         i_ready,
  output logic         o_busy
);

  localparam int M    = N - 1;
  localparam int ITER = N - 1 + Q + ROUND;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   cnt;
  logic [ITER-1:0] dvd;
  logic [M-1:0]    dsr;
  logic [N-1:0]    rem;
  logic [ITER-1:0] qext;
  logic            sign;

  logic            dbz_in;
  logic            sign_in;
  logic [N-1:0]    rem_sh;
  logic            ge;
  logic [N-1:0]    rem_nx;
  logic [ITER:0]   qm;
  logic            ovf;
  logic [M-1:0]    mag;
  logic            sgn;

  assign dbz_in  = (i_divisor[M-1:0] == '0);
  assign sign_in = i_dividend[N-1] ^ i_divisor[N-1];

  assign o_ready = (state == IDLE);
  assign o_valid = (state == DONE);
  assign o_busy  = (state == CALC);

  always_ff @(posedge i_clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (i_valid) state_nx = dbz_in ? DONE : CALC;
      CALC: if (cnt == '0) state_nx = DONE;
      DONE: if (i_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Restoring step; the dropped top bit still forces a subtract
  assign rem_sh = {rem[N-2:0], dvd[ITER-1]};
  assign ge     = rem[N-1] | (rem_sh >= {1'b0, dsr});
  assign rem_nx = ge ? rem_sh - {1'b0, dsr} : rem_sh;

  if (ROUND != 0) begin : g_rnd
    assign qm = ({1'b0, qext} + {{ITER{1'b0}}, 1'b1}) >> 1;
  end else begin : g_trn
    assign qm = {1'b0, qext};
  end

  assign ovf = |qm[ITER:M];
  assign mag = (ovf && SATURATE != 0) ? '1 : qm[M-1:0];
  assign sgn = sign && (mag != '0);

  always_ff @(posedge i_clk) begin
    if (rst) begin
      o_quotient <= '0;
      o_overflow <= 1'b0;
      o_dbz      <= 1'b0;
      cnt        <= '0;
      dvd        <= '0;
      dsr        <= '0;
      rem        <= '0;
      qext       <= '0;
      sign       <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (i_valid) begin
            dvd  <= {i_dividend[M-1:0], {(Q + ROUND){1'b0}}};
            dsr  <= i_divisor[M-1:0];
            rem  <= '0;
            qext <= '0;
            cnt  <= CW'(ITER);
            sign <= sign_in;
            o_overflow <= 1'b0;
            if (dbz_in) begin
              o_dbz      <= 1'b1;
              o_quotient <= {sign_in, {M{1'b1}}};
            end
          end
        end
        CALC: begin
          if (cnt != '0) begin
            rem  <= rem_nx;
            qext <= {qext[ITER-2:0], ge};
            dvd  <= dvd << 1;
            cnt  <= cnt - 1'b1;
          end else begin
            o_quotient <= {sgn, mag};
            o_overflow <= ovf;
            o_dbz      <= 1'b0;
          end
        end
        DONE: begin
          if (i_ready) begin
            o_overflow <= 1'b0;
            o_dbz      <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_div_seq.sv
// Bench for fixed_div_seq: three configurations side by side,
// spec vectors, handshake/reset sequences and random model checks.
module tb_fixed_div_seq;

  localparam int Q = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [31:0]       a_in = '0;
  logic [31:0]       b_in = '0;
  logic              vin = 1'b0;
  logic              rin = 1'b0;
  logic [2:0][31:0]  q;
  logic [2:0]        ovf, dbz, vld, rdy, bsy;

  int cmp_cnt = 0;
  int bad_cnt = 0;

  always #5 clk = ~clk;

  fixed_div_seq #(.N(32), .Q(15), .ROUND(0), .SATURATE(1)) d0 (
    .i_clk(clk), .rst(rst), .i_dividend(a_in), .i_divisor(b_in),
    .i_valid(vin), .o_ready(rdy[0]), .o_quotient(q[0]),
    .o_overflow(ovf[0]), .o_dbz(dbz[0]), .o_valid(vld[0]),
    .i_ready(rin), .o_busy(bsy[0]));

  fixed_div_seq #(.N(32), .Q(15), .ROUND(1), .SATURATE(1)) d1 (
    .i_clk(clk), .rst(rst), .i_dividend(a_in), .i_divisor(b_in),
    .i_valid(vin), .o_ready(rdy[1]), .o_quotient(q[1]),
    .o_overflow(ovf[1]), .o_dbz(dbz[1]), .o_valid(vld[1]),
    .i_ready(rin), .o_busy(bsy[1]));

  fixed_div_seq #(.N(32), .Q(15), .ROUND(0), .SATURATE(0)) d2 (
    .i_clk(clk), .rst(rst), .i_dividend(a_in), .i_divisor(b_in),
    .i_valid(vin), .o_ready(rdy[2]), .o_quotient(q[2]),
    .o_overflow(ovf[2]), .o_dbz(dbz[2]), .o_valid(vld[2]),
    .i_ready(rin), .o_busy(bsy[2]));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [2:0]  eov;
    logic        ed;
  } vec_t;

  vec_t tv[7];

  task automatic chk(input string nm, input string tag,
                     input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s.%s: got %h want %h", nm, tag, act, exp);
    end
  endtask

  // Plain-arithmetic reference: quotient = |a| * 2^(Q+rnd) / |b|
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                input int rnd, input int sat,
                                output logic [31:0] qo, output logic ov);
    longint unsigned ma, mb, qe, qmv;
    logic s;
    logic [30:0] mg;
    ma = 64'(a[30:0]);
    mb = 64'(b[30:0]);
    s  = a[31] ^ b[31];
    if (mb == 0) begin
      qo = {s, 31'h7FFF_FFFF};
      ov = 1'b0;
      return;
    end
    qe  = (ma << (Q + rnd)) / mb;
    qmv = (rnd != 0) ? (qe + 1) / 2 : qe;
    ov  = (qmv >= 64'h8000_0000);
    mg  = qmv[30:0];
    if (ov && sat != 0) mg = '1;
    if (mg == '0) s = 1'b0;
    qo = {s, mg};
  endfunction

  task automatic run_op(input string nm,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e0, input logic [31:0] e1,
                        input logic [31:0] e2, input logic [2:0] eov,
                        input logic ed, input bit poke);
    logic [31:0] ex[3];
    int lat[3];
    int el;
    ex[0] = e0;
    ex[1] = e1;
    ex[2] = e2;
    lat = '{-1, -1, -1};
    chk(nm, "rdy", 64'(rdy), 64'(3'b111));
    a_in = a;
    b_in = b;
    vin  = 1'b1;
    @(posedge clk);
    #1;
    vin = 1'b0;
    for (int t = 1; t <= 60 && (lat[0] < 0 || lat[1] < 0 || lat[2] < 0); t++) begin
      if (poke && t == 5) begin
        chk(nm, "busy", 64'({bsy, rdy}), 64'({3'b111, 3'b000}));
        a_in = ~a;
        b_in = 32'h0001_0000;
        vin  = 1'b1;
      end
      if (poke && t == 12) vin = 1'b0;
      @(posedge clk);
      #1;
      for (int d = 0; d < 3; d++)
        if (vld[d] && lat[d] < 0) lat[d] = t;
    end
    vin = 1'b0;
    for (int d = 0; d < 3; d++) begin
      el = ed ? 1 : 47 + ((d == 1) ? 1 : 0);
      chk(nm, $sformatf("lat%0d", d), 64'(lat[d]), 64'(el));
      chk(nm, $sformatf("q%0d", d), 64'(q[d]), 64'(ex[d]));
      chk(nm, $sformatf("flags%0d", d), 64'({ovf[d], dbz[d]}), 64'({eov[d], ed}));
    end
    for (int h = 0; h < 5; h++) begin
      @(posedge clk);
      #1;
      chk(nm, "hold", {vld, rdy[0], q[0], ovf[0], dbz[0]},
          {3'b111, 1'b0, e0, eov[0], ed});
    end
    rin = 1'b1;
    @(posedge clk);
    #1;
    rin = 1'b0;
    chk(nm, "release", 64'({vld, ovf, dbz, rdy}), 64'({9'b0, 3'b111}));
    chk(nm, "qheld", 64'(q[0]), 64'(e0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb, m0, m1, m2;
    logic o0, o1, o2;
    int mode;

    tv[0] = '{32'h0001_8000, 32'h0001_0000, 32'h0000_C000, 32'h0000_C000,
              32'h0000_C000, 3'b000, 1'b0};
    tv[1] = '{32'h8001_8000, 32'h0001_0000, 32'h8000_C000, 32'h8000_C000,
              32'h8000_C000, 3'b000, 1'b0};
    tv[2] = '{32'h8000_0000, 32'h0000_8000, 32'h0000_0000, 32'h0000_0000,
              32'h0000_0000, 3'b000, 1'b0};
    tv[3] = '{32'h0000_8000, 32'h0001_8000, 32'h0000_2AAA, 32'h0000_2AAB,
              32'h0000_2AAA, 3'b000, 1'b0};
    tv[4] = '{32'h0002_8000, 32'h0000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
              32'h7FFF_FFFF, 3'b000, 1'b1};
    tv[5] = '{32'h8002_8000, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'hFFFF_FFFF, 3'b000, 1'b1};
    tv[6] = '{32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
              32'h7FFF_8000, 3'b111, 1'b0};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset", "ctl", 64'({rdy, vld, bsy}), 64'({3'b111, 6'b0}));
    chk("reset", "data", {q, ovf, dbz}, '0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++)
      run_op($sformatf("vec%0d", i), tv[i].a, tv[i].b, tv[i].e0,
             tv[i].e1, tv[i].e2, tv[i].eov, tv[i].ed, 1'b0);

    run_op("poke", 32'h0000_8000, 32'h0001_8000, 32'h0000_2AAA,
           32'h0000_2AAB, 32'h0000_2AAA, 3'b000, 1'b0, 1'b1);

    a_in = 32'h0001_8000;
    b_in = 32'h0001_0000;
    vin  = 1'b1;
    @(posedge clk);
    #1;
    vin = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("abort", "busy", 64'(bsy), 64'(3'b111));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort", "ctl", 64'({bsy, rdy, vld}), 64'({3'b000, 3'b111, 3'b000}));
    chk("abort", "data", {q, ovf, dbz}, '0);

    run_op("fresh", 32'h8001_8000, 32'h0001_0000, 32'h8000_C000,
           32'h8000_C000, 32'h8000_C000, 3'b000, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      mode = $urandom_range(0, 3);
      ra = $urandom;
      rb = $urandom;
      if (mode == 1) rb[30:0] = 31'($urandom_range(1, 255));
      if (mode == 2) rb[30:0] = '0;
      if (mode == 3) ra[30:0] = 31'($urandom_range(0, 65535));
      model(ra, rb, 0, 1, m0, o0);
      model(ra, rb, 1, 1, m1, o1);
      model(ra, rb, 0, 0, m2, o2);
      run_op($sformatf("rnd%0d", i), ra, rb, m0, m1, m2,
             {o2, o1, o0}, (rb[30:0] == '0), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, bad_cnt);
    $finish;
  end

endmodule
